if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register. Takes pc_i each cycle,

---
 rtl/if_fetch_unit.sv | 133 +++++++++++++
 tb/tb_if_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ==== if_fetch_unit : IF stage, req/gnt/rvalid fetch into in-order {pc,instr} buffer ====
// ==== Option macro FETCH_MISALIGN_CHECK_EN : misaligned PCs queue a flagged entry. Rev 1.0 ==
module if_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic              id_misalign_o,
  input  logic              id_ready_i
);
  localparam int          PW      = $clog2(BUF_DEPTH);
  localparam int          CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(BUF_DEPTH);

  // Slots are allocated at issue time so misaligned entries keep program order.
  logic [ADDR_W-1:0]    slot_pc    [BUF_DEPTH];
  logic [DATA_W-1:0]    slot_instr [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] slot_done;
  logic [PW-1:0]        tag_slot   [BUF_DEPTH];
  logic [PW-1:0]        head, tail, tag_rd, tag_wr;
  logic [CW-1:0]        used, pend, dsc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic [BUF_DEPTH-1:0] slot_mis;
`endif

  logic        misaligned, pop, take, issue, mis_push, fill, drop;
  logic [CW:0] credit;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign id_valid_o  = slot_done[head];
  assign pop         = id_valid_o & id_ready_i;
  // Credit = allocated slots (after this pop) + responses still to be discarded.
  assign credit      = {1'b0, used} - {{CW{1'b0}}, pop} + {1'b0, dsc};
  assign take        = rst_n_i & ~flush_i & (credit < DEPTH_C);
  assign imem_req_o  = take & ~misaligned;
  assign imem_addr_o = pc_i;
  assign issue       = imem_req_o & imem_gnt_i;
  assign mis_push    = take & misaligned;
  assign stall_o     = ~rst_n_i | (~flush_i & ~(issue | mis_push));
  assign drop        = imem_rvalid_i & (dsc != '0);
  assign fill        = imem_rvalid_i & (dsc == '0) & ~flush_i;

  assign id_pc_o     = id_valid_o ? slot_pc[head]    : '0;
  assign id_instr_o  = id_valid_o ? slot_instr[head] : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign id_misalign_o = id_valid_o & slot_mis[head];
`else
  assign id_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head      <= '0;
      tail      <= '0;
      tag_rd    <= '0;
      tag_wr    <= '0;
      used      <= '0;
      pend      <= '0;
      dsc       <= '0;
      slot_done <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      slot_mis  <= '0;
`endif
      for (int i = 0; i < BUF_DEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
        tag_slot[i]   <= '0;
      end
    end else if (flush_i) begin
      head      <= '0;
      tail      <= '0;
      tag_rd    <= '0;
      tag_wr    <= '0;
      used      <= '0;
      pend      <= '0;
      slot_done <= '0;
      // Live fetches become discards; a response arriving now is dropped either way.
      dsc       <= dsc + pend - CW'(imem_rvalid_i);
    end else begin
      if (pop) begin
        slot_done[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (fill) begin
        slot_instr[tag_slot[tag_rd]] <= imem_rdata_i;
        slot_done[tag_slot[tag_rd]]  <= 1'b1;
        tag_rd                       <= tag_rd + PW'(1);
      end
      if (issue) begin
        slot_pc[tail]    <= pc_i;
        tag_slot[tag_wr] <= tail;
        tag_wr           <= tag_wr + PW'(1);
        tail             <= tail + PW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        slot_mis[tail]   <= 1'b0;
`endif
      end
      if (mis_push) begin
        slot_pc[tail]    <= pc_i;
        slot_instr[tail] <= '0;
        slot_done[tail]  <= 1'b1;
        tail             <= tail + PW'(1);
`ifdef FETCH_MISALIGN_CHECK_EN
        slot_mis[tail]   <= 1'b1;
`endif
      end
      used <= used + CW'(issue | mis_push) - CW'(pop);
      pend <= pend + CW'(issue) - CW'(fill);
      dsc  <= dsc - CW'(drop);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// tb_if_fetch_unit : directed checks of if_fetch_unit with a fixed-latency in-order memory model.
module tb_if_fetch_unit;
  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct packed { logic mis; logic [31:0] pc; logic [31:0] instr; } pop_t;
  typedef struct packed { logic [31:0] due; logic [31:0] addr; } mreq_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, gnt, rvalid, ready;
  logic [31:0] pc, rdata;
  logic        stall, imem_req, id_valid, id_misalign;
  logic [31:0] imem_addr, id_pc, id_instr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, lat;
  logic [31:0] flush_target;
  logic        s_stall, s_req;
  logic [31:0] s_addr;
  pop_t        pops[$];
  mreq_t       mq[$];

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(32), .DATA_W(32), .BUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc), .stall_o(stall), .flush_i(flush),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
    .id_misalign_o(id_misalign), .id_ready_i(ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [31:0] exp_pc,
                           input logic exp_mis);
    logic [31:0] p, i;
    logic        m;
    if (idx < pops.size()) begin
      p = pops[idx].pc; i = pops[idx].instr; m = pops[idx].mis;
    end else begin
      p = 'x; i = 'x; m = 'x;
    end
    check_eq({tag, "_pc"}, p, exp_pc);
    check_eq({tag, "_instr"}, i, exp_mis ? 32'h0 : mem_word(exp_pc));
    check_eq({tag, "_mis"}, m, exp_mis);
  endtask

  // One bus cycle: memory drives rvalid, the PC register and ID sample at negedge.
  task automatic tick();
    pop_t        e;
    mreq_t       r;
    logic [31:0] nxt;
    rvalid = (mq.size() != 0) && (mq[0].due <= 32'(cyc));
    rdata  = rvalid ? mem_word(mq[0].addr) : 32'h0;
    @(negedge clk);
    s_stall = stall; s_req = imem_req; s_addr = imem_addr;
    if (id_valid && ready) begin
      e.mis = id_misalign; e.pc = id_pc; e.instr = id_instr;
      pops.push_back(e);
    end
    if (imem_req && gnt) begin
      r.due = 32'(cyc + lat); r.addr = imem_addr;
      mq.push_back(r);
    end
    if (rvalid) void'(mq.pop_front());
    nxt = flush ? flush_target : (stall ? pc : pc + 32'd4);
    @(posedge clk);
    #1;
    cyc++;
    pc = nxt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; gnt = 1'b1; ready = 1'b1;
    rvalid = 1'b0; rdata = '0; pc = BASE; lat = 1;
    mq.delete(); pops.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; gnt = 1'b1; ready = 1'b1;
    rvalid = 1'b0; rdata = '0; pc = BASE; lat = 1; flush_target = '0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_stall", stall, 1);
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_id_valid", id_valid, 0);
    check_eq("rst_id_pc", id_pc, 0);
    check_eq("rst_id_instr", id_instr, 0);
    check_eq("rst_id_mis", id_misalign, 0);

    // Streaming: one entry per cycle, zero bubbles
    do_reset();
    repeat (8) tick();
    check_eq("t1_pops", pops.size(), 6);
    for (int k = 0; k < 4; k++) check_pop($sformatf("t1_pop%0d", k), k, BASE + 32'(4*k), 1'b0);
    check_eq("t1_stall", s_stall, 0);
    check_eq("t1_valid_before_arst", id_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_arst_valid", id_valid, 0);
    check_eq("t1_arst_stall", stall, 1);
    check_eq("t1_arst_req", imem_req, 0);

    // Backpressure with a full buffer, then pop and issue in the same cycle
    do_reset();
    ready = 1'b0;
    repeat (4) tick();
    check_eq("t2_full_stall", s_stall, 1);
    check_eq("t2_full_req", s_req, 0);
    check_eq("t2_full_addr", s_addr, BASE + 32'h8);
    check_eq("t2_head_pc", id_pc, BASE);
    ready = 1'b1;
    tick();
    check_eq("t2_resume_req", s_req, 1);
    check_eq("t2_resume_stall", s_stall, 0);
    tick();
    check_pop("t2_pop0", 0, BASE, 1'b0);
    check_pop("t2_pop1", 1, BASE + 32'h4, 1'b0);

    // Grant withheld for three cycles
    do_reset();
    repeat (2) tick();
    gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("t3_stall%0d", k), s_stall, 1);
      check_eq($sformatf("t3_addr%0d", k), s_addr, BASE + 32'h8);
    end
    check_eq("t3_drained_valid", id_valid, 0);
    check_eq("t3_pops_during", pops.size(), 2);
    gnt = 1'b1;
    repeat (3) tick();
    check_pop("t3_pop2", 2, BASE + 32'h8, 1'b0);

    // Flush with two fetches in flight, 3-cycle memory
    do_reset();
    lat = 3;
    repeat (2) tick();
    flush = 1'b1; flush_target = BASE + 32'h100;
    tick();
    flush = 1'b0;
    check_eq("t4_flush_stall", s_stall, 0);
    check_eq("t4_flush_req", s_req, 0);
    check_eq("t4_post_valid", id_valid, 0);
    repeat (8) tick();
    check_eq("t4_pops", pops.size(), 2);
    check_pop("t4_pop0", 0, BASE + 32'h100, 1'b0);
    check_pop("t4_pop1", 1, BASE + 32'h104, 1'b0);

    // Flush coinciding with rvalid, second flush one cycle later
    do_reset();
    lat = 2;
    repeat (2) tick();
    flush = 1'b1; flush_target = BASE + 32'h100;
    tick();
    flush_target = BASE + 32'h200;
    tick();
    flush = 1'b0;
    tick();
    check_eq("t5_req_a", s_req, 1);
    tick();
    check_eq("t5_req_b", s_req, 1);
    repeat (4) tick();
    check_eq("t5_pops", pops.size(), 2);
    check_pop("t5_pop0", 0, BASE + 32'h200, 1'b0);
    check_pop("t5_pop1", 1, BASE + 32'h204, 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC queued in order behind an in-flight fetch
    do_reset();
    lat = 2;
    tick();
    pc = BASE + 32'h2;
    tick();
    check_eq("t6_mis_req", s_req, 0);
    check_eq("t6_mis_stall", s_stall, 0);
    pc = BASE + 32'h8;
    repeat (4) tick();
    check_pop("t6_pop0", 0, BASE, 1'b0);
    check_pop("t6_pop1", 1, BASE + 32'h2, 1'b1);
`else
    // Misaligned PC passes straight through to memory
    do_reset();
    pc = BASE + 32'h2;
    tick();
    check_eq("t6_req", s_req, 1);
    check_eq("t6_addr", s_addr, BASE + 32'h2);
    repeat (3) tick();
    check_pop("t6_pop0", 0, BASE + 32'h2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
